// File: rtl/ram_pkg.sv
// Shared types and helpers for the clearable simple dual-port RAM.
// Holds the clear-engine state encoding and data-width helpers.
package ram_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } clr_state_e;

  function automatic int num_bytes(input int dw);
    return dw / 8;
  endfunction

  function automatic bit dw_legal(input int dw);
    return (dw > 0) && ((dw % 8) == 0);
  endfunction

endpackage

// File: rtl/ram_clear_ctrl.sv
// Clear engine: sweeps CLEAR_VALUE over every word, one per cycle.
// It owns the RAM write port while busy is high.
module ram_clear_ctrl
  import ram_pkg::*;
#(
  parameter int                    ADDR_WIDTH     = 12,
  parameter int                    DATA_WIDTH     = 32,
  parameter bit                    CLEAR_ON_RESET = 1'b1,
  parameter logic [DATA_WIDTH-1:0] CLEAR_VALUE    = '0
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  clear_req,
  output logic                  busy,
  output logic [ADDR_WIDTH-1:0] o_clr_addr,
  output logic [DATA_WIDTH-1:0] o_clr_data
);

  localparam logic [ADDR_WIDTH:0] CNT_ONE = {{ADDR_WIDTH{1'b0}}, 1'b1};

  clr_state_e            r_state, w_state_nxt;
  logic [ADDR_WIDTH:0]   r_cnt, w_cnt_nxt, w_cnt_inc;

  assign w_cnt_inc = r_cnt + CNT_ONE;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= CLEAR_ON_RESET ? ST_CLEAR : ST_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // The extra counter bit flags the word after DEPTH-1, ending the sweep.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      ST_IDLE: begin
        if (clear_req) begin
          w_state_nxt = ST_CLEAR;
          w_cnt_nxt   = '0;
        end
      end
      ST_CLEAR: begin
        if (w_cnt_inc[ADDR_WIDTH]) begin
          w_state_nxt = ST_IDLE;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = w_cnt_inc;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  assign busy       = (r_state == ST_CLEAR);
  assign o_clr_addr = r_cnt[ADDR_WIDTH-1:0];
  assign o_clr_data = CLEAR_VALUE;

endmodule

// File: rtl/dual_port_ram_clr.sv
// Single-clock simple dual-port RAM with byte enables, write-first
// forwarding, optional output register and a built-in clear engine.
module dual_port_ram_clr
  import ram_pkg::*;
#(
  parameter int                    DATA_WIDTH     = 32,
  parameter int                    ADDR_WIDTH     = 12,
  parameter int                    OUTPUT_REG     = 1,
  parameter bit                    CLEAR_ON_RESET = 1'b1,
  parameter logic [DATA_WIDTH-1:0] CLEAR_VALUE    = '0
) (
  input  logic                    clock,
  input  logic                    reset_n,
  input  logic                    clear_req,
  output logic                    busy,
  input  logic                    wr_en,
  input  logic [ADDR_WIDTH-1:0]   wr_addr,
  input  logic [DATA_WIDTH/8-1:0] wr_byte_en,
  input  logic [DATA_WIDTH-1:0]   wr_data,
  input  logic                    rd_en,
  input  logic [ADDR_WIDTH-1:0]   rd_addr,
  output logic [DATA_WIDTH-1:0]   rd_data,
  output logic                    rd_valid
);

  localparam int NB     = num_bytes(DATA_WIDTH);
  localparam int DEPTH  = 2 ** ADDR_WIDTH;
  localparam int STAGES = (OUTPUT_REG != 0) ? 2 : 1;

  generate
    if (!dw_legal(DATA_WIDTH)) begin : g_bad_dw
      $error("DATA_WIDTH must be a non-zero multiple of 8");
    end
  endgenerate

  logic                  w_clr_busy;
  logic [ADDR_WIDTH-1:0] w_clr_addr;
  logic [DATA_WIDTH-1:0] w_clr_data;

  ram_clear_ctrl #(
    .ADDR_WIDTH     (ADDR_WIDTH),
    .DATA_WIDTH     (DATA_WIDTH),
    .CLEAR_ON_RESET (CLEAR_ON_RESET),
    .CLEAR_VALUE    (CLEAR_VALUE)
  ) u_clr (
    .clock      (clock),
    .reset_n    (reset_n),
    .clear_req  (clear_req),
    .busy       (w_clr_busy),
    .o_clr_addr (w_clr_addr),
    .o_clr_data (w_clr_data)
  );

  assign busy = w_clr_busy;

  // Write-port mux: the clear engine takes the port for the whole sweep.
  logic                  w_we;
  logic [NB-1:0]         w_wbe;
  logic [ADDR_WIDTH-1:0] w_waddr;
  logic [DATA_WIDTH-1:0] w_wdata;
  logic                  w_rd_acc;

  always_comb begin
    w_we    = wr_en;
    w_wbe   = wr_byte_en;
    w_waddr = wr_addr;
    w_wdata = wr_data;
    if (w_clr_busy) begin
      w_we    = 1'b1;
      w_wbe   = '1;
      w_waddr = w_clr_addr;
      w_wdata = w_clr_data;
    end
  end

  assign w_rd_acc = rd_en & ~w_clr_busy;

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic [DATA_WIDTH-1:0] r_ram_q;

  always_ff @(posedge clock) begin
    for (int b = 0; b < NB; b++) begin
      if (w_we && w_wbe[b]) r_mem[w_waddr][8*b +: 8] <= w_wdata[8*b +: 8];
    end
    if (w_rd_acc) r_ram_q <= r_mem[rd_addr];
  end

  // Forwarding overlay registered beside the RAM read. Reset selects all
  // bytes from zeroed overlay data so the read stage shows 0 out of reset.
  logic [NB-1:0]         r_fwd_be;
  logic [DATA_WIDTH-1:0] r_fwd_data;
  logic [DATA_WIDTH-1:0] w_s1_data;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_fwd_be   <= '1;
      r_fwd_data <= '0;
    end else if (w_rd_acc) begin
      r_fwd_be   <= (wr_en && (wr_addr == rd_addr)) ? wr_byte_en : '0;
      r_fwd_data <= wr_data;
    end
  end

  always_comb begin
    w_s1_data = r_ram_q;
    for (int b = 0; b < NB; b++) begin
      if (r_fwd_be[b]) w_s1_data[8*b +: 8] = r_fwd_data[8*b +: 8];
    end
  end

  logic [STAGES:1] r_vld_pipe;
  logic [STAGES:0] w_vld_pipe;

  assign w_vld_pipe = {r_vld_pipe, w_rd_acc};

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) r_vld_pipe <= '0;
    else          r_vld_pipe <= w_vld_pipe[STAGES-1:0];
  end

  assign rd_valid = r_vld_pipe[STAGES];

  generate
    if (OUTPUT_REG != 0) begin : g_oreg
      logic [DATA_WIDTH-1:0] r_out;
      always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n)          r_out <= '0;
        else if (r_vld_pipe[1]) r_out <= w_s1_data;
      end
      assign rd_data = r_out;
    end else begin : g_noreg
      assign rd_data = w_s1_data;
    end
  endgenerate

endmodule

// File: doc/dual_port_ram_clr.md
Name: dual_port_ram_clr

Overview:
Parametrised single-clock simple dual-port RAM: one write port and one read port, both in the `clock` domain.
- Generalises the fixed 4k x 8 buffer in data width, depth, byte-enable writes and an optional output register.
- Adds write-first forwarding for same-address read/write.
- Adds a built-in clear engine that fills the array with a constant after reset or on request.
- Used for line/pixel buffers and DMA staging RAMs in the HDMI and DMA paths.

Parameters:
DATA_WIDTH, 32, word width in bits; must be a multiple of 8.
ADDR_WIDTH, 12, address bits; DEPTH = 2**ADDR_WIDTH words.
OUTPUT_REG, 1, 0 = read latency 1 cycle; 1 = extra output register, latency 2.
CLEAR_ON_RESET, 1, 1 = start a clear sweep automatically when reset deasserts.
CLEAR_VALUE, 0, DATA_WIDTH-bit value written by the clear engine.

Ports:
clock  in  1  single clock, rising edge.
reset_n  in  1  asynchronous, active-low reset.
clear_req  in  1  one-cycle pulse: start a clear sweep.
busy  out  1  high while the clear sweep runs.
wr_en  in  1  write strobe.
wr_addr  in  ADDR_WIDTH  write address.
wr_byte_en  in  DATA_WIDTH/8  per-byte write enable.
wr_data  in  DATA_WIDTH  write data.
rd_en  in  1  read strobe.
rd_addr  in  ADDR_WIDTH  read address.
rd_data  out  DATA_WIDTH  read data.
rd_valid  out  1  rd_data holds the result of an accepted read.

Behaviour:
- Interface: one clock; reset is asynchronous and active-low (clock port `clock`, reset port `reset_n`).
- Reset (reset_n=0):
  - rd_data=0, rd_valid=0, all pipeline valids cleared, clear counter=0.
  - FSM forced to CLEAR if CLEAR_ON_RESET=1 (busy=1 during and after reset), else IDLE (busy=0).
  - Array contents are not touched by reset.
- FSM states IDLE, CLEAR:
  - IDLE -> CLEAR: on clear_req=1.
  - CLEAR: writes CLEAR_VALUE to address cnt each cycle, cnt 0..DEPTH-1.
  - CLEAR -> IDLE: after the cycle that writes DEPTH-1. The sweep takes exactly DEPTH cycles with busy=1.
  - clear_req while in CLEAR is ignored (no restart, no queueing).
  - Reset asserted mid-sweep aborts the sweep; with CLEAR_ON_RESET=1 it restarts from address 0.
- While busy=1:
  - wr_en and rd_en are ignored: no array write, no read accepted.
  - rd_valid stays 0.
  - Reads already in the output pipeline at CLEAR entry complete normally.
- Write (IDLE, wr_en=1):
  - Byte i of mem[wr_addr] is updated from wr_data[8i+7:8i] iff wr_byte_en[i]=1.
  - wr_byte_en=0 means no change.
- Read (IDLE, rd_en=1):
  - OUTPUT_REG=0: rd_data/rd_valid update at the edge after acceptance, latency 1.
  - OUTPUT_REG=1: latency 2.
  - rd_valid is a one-cycle pulse per accepted read; back-to-back reads give one result per cycle, fully pipelined.
  - rd_data holds its last value when rd_valid=0.
- Same-cycle read and write to the same address (write-first): the read returns the old word with the enabled bytes replaced by wr_data. Different addresses do not interact.
- Address arithmetic: no wrap logic is needed. Addresses are exactly ADDR_WIDTH bits and the clear counter is ADDR_WIDTH+1 bits, so terminal detection needs no overflow.
- Array is inferable as block RAM: no reset on the memory, one write port and one read port.

Decomposition:
- Shared package ram_pkg: FSM state encoding (ST_IDLE, ST_CLEAR), function for DATA_WIDTH/8, and a parameter-legality check (DATA_WIDTH%8==0).
- One sub-module, ram_clear_ctrl: FSM, counter and busy. It drives a write-port mux select, address and data into the main array.
- Byte-merge forwarding and the output pipeline stay in the top module.

Test Plan:
- Reset with CLEAR_ON_RESET=1, ADDR_WIDTH=4, CLEAR_VALUE=32'hA5A5A5A5:
  - busy=1 for exactly 16 cycles after reset_n rises.
  - Reading addresses 0..15 afterwards returns A5A5A5A5.
  - rd_valid=0 throughout the sweep.
- Byte-enable write: write 32'h11223344 to addr 3 with be=4'b1111, then 32'hAABBCCDD with be=4'b0101; read addr 3 returns 32'h11BB33DD with latency 2 (OUTPUT_REG=1) or 1 (OUTPUT_REG=0).
- Forwarding: mem[7]=0, then same cycle wr addr 7 data 32'hDEADBEEF be=4'b1100 plus rd addr 7 -> rd_data=32'hDEAD0000.
- Streaming: 16 back-to-back reads -> 16 consecutive rd_valid pulses with data in address order, no bubbles.
- Clear request mid-traffic: pulse clear_req while writing.
  - Writes during busy are dropped; a second clear_req during the sweep does not extend busy beyond DEPTH cycles.
  - All words read CLEAR_VALUE afterwards.
- Reset mid-sweep: assert reset_n=0 at cnt=9 for 2 cycles -> rd_data=0, rd_valid=0 immediately (asynchronous); the sweep restarts at 0 and busy lasts DEPTH cycles after release.
